// File: rtl/regfile_mp_if.sv
// Register file access bundle: three read ports, one byte-enabled
// write port and the soft-clear handshake.
interface regfile_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0]   regA;
    logic [AW-1:0]   regB;
    logic [AW-1:0]   regC;
    logic [DW-1:0]   Adat;
    logic [DW-1:0]   Bdat;
    logic [DW-1:0]   Cdat;
    logic [AW-1:0]   regW;
    logic [DW-1:0]   Wdat;
    logic [DW/8-1:0] Wbe;
    logic            RegWrite;
    logic            clr_req;
    logic            busy;
    logic            clr_done;

    modport master (
        output regA, regB, regC,
        output regW, Wdat, Wbe, RegWrite,
        output clr_req,
        input  Adat, Bdat, Cdat,
        input  busy, clr_done
    );

    modport slave (
        input  regA, regB, regC,
        input  regW, Wdat, Wbe, RegWrite,
        input  clr_req,
        output Adat, Bdat, Cdat,
        output busy, clr_done
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte-enabled writes,
// optional zero register / bypass, and a soft-clear sweep.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic        btn,
    input logic        rst_n,
    regfile_mp_if.slave rf
);
    localparam int NB = DW / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [1:0]    state;
    logic [AW-1:0] ptr;
    logic          busy_q;
    logic          done_q;

    logic          commit;
    logic [DW-1:0] wold;
    logic [DW-1:0] wmerge;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic ok;
        ok = ({1'b0, a} < DEPTH_W);
        if (ZERO_REG != 0 && a == '0) ok = 1'b0;
        return ok;
    endfunction

    // Bypass only follows a write that will actually commit this edge.
    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = '0;
        if (addr_ok(a)) begin
            v = mem[a];
            if (BYPASS != 0 && commit && a == rf.regW) v = wmerge;
        end
        return v;
    endfunction

    always_comb begin
        wold = '0;
        if (addr_ok(rf.regW)) wold = mem[rf.regW];
        wmerge = wold;
        for (int b = 0; b < NB; b++) begin
            if (rf.Wbe[b]) wmerge[8*b +: 8] = rf.Wdat[8*b +: 8];
        end
    end

    assign commit = rf.RegWrite && !busy_q && addr_ok(rf.regW);

    assign rf.Adat     = rd(rf.regA);
    assign rf.Bdat     = rd(rf.regB);
    assign rf.Cdat     = rd(rf.regC);
    assign rf.busy     = busy_q;
    assign rf.clr_done = done_q;

    always_ff @(negedge btn or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (commit) begin
                for (int b = 0; b < NB; b++) begin
                    if (rf.Wbe[b]) mem[rf.regW][8*b +: 8] <= rf.Wdat[8*b +: 8];
                end
            end
            case (state)
                IDLE: begin
                    if (rf.clr_req) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= '0;
                    if (ptr == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: vector table, hand sequences for clear/reset
// corners, and random traffic against a behavioural model.
module tb_regfile_mp;
    logic btn = 1'b1;
    logic rst_n = 1'b1;

    regfile_mp_if #(.DW(32), .AW(5)) rf ();
    regfile_mp_if #(.DW(32), .AW(5)) rf1 ();

    regfile_mp #(.DW(32), .AW(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1))
        dut (.btn(btn), .rst_n(rst_n), .rf(rf));
    regfile_mp #(.DW(32), .AW(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(0))
        dut1 (.btn(btn), .rst_n(rst_n), .rf(rf1));

    assign rf1.regA     = rf.regA;
    assign rf1.regB     = rf.regB;
    assign rf1.regC     = rf.regC;
    assign rf1.regW     = rf.regW;
    assign rf1.Wdat     = rf.Wdat;
    assign rf1.Wbe      = rf.Wbe;
    assign rf1.RegWrite = rf.RegWrite;
    assign rf1.clr_req  = rf.clr_req;

    always #5 btn = ~btn;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [32];
    bit          m_busy;
    bit          m_done;
    int          m_ptr;

    logic [31:0] s_a, s_b, s_c, s1_b;
    logic        s_busy, s_done;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] v;
        v = old;
        for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_rd(input int a, input bit we, input int wa,
                                         input logic [31:0] wd, input logic [3:0] be);
        if (a == 0) return 32'h0;
        if (we && !m_busy && a == wa && wa != 0) return merge(m_mem[a], wd, be);
        return m_mem[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_busy = 0;
        m_done = 0;
        m_ptr  = 0;
    endtask

    task automatic m_edge(input bit we, input int wa, input logic [31:0] wd,
                          input logic [3:0] be, input bit clr);
        if (we && !m_busy && wa != 0) m_mem[wa] = merge(m_mem[wa], wd, be);
        if (m_busy) begin
            m_mem[m_ptr] = 32'h0;
            m_ptr++;
            if (m_ptr == 32) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (clr) begin
            m_busy = 1;
            m_ptr  = 0;
        end
    endtask

    // Drive after the falling edge, sample on the rising edge, commit on the next fall.
    task automatic cycle(input bit we, input int wa, input logic [31:0] wd,
                         input logic [3:0] be, input int a, input int b,
                         input int c, input bit clr);
        rf.RegWrite = we;
        rf.regW     = 5'(wa);
        rf.Wdat     = wd;
        rf.Wbe      = be;
        rf.regA     = 5'(a);
        rf.regB     = 5'(b);
        rf.regC     = 5'(c);
        rf.clr_req  = clr;
        @(posedge btn);
        s_a    = rf.Adat;
        s_b    = rf.Bdat;
        s_c    = rf.Cdat;
        s1_b   = rf1.Bdat;
        s_busy = rf.busy;
        s_done = rf.clr_done;
        chk("Adat", s_a, m_rd(a, we, wa, wd, be));
        chk("Bdat", s_b, m_rd(b, we, wa, wd, be));
        chk("Cdat", s_c, m_rd(c, we, wa, wd, be));
        chk("busy", {31'b0, s_busy}, {31'b0, m_busy});
        chk("clr_done", {31'b0, s_done}, {31'b0, m_done});
        @(negedge btn);
        m_edge(we, wa, wd, be, clr);
        #1;
    endtask

    typedef struct {
        bit          we;
        int          wa;
        logic [31:0] wd;
        logic [3:0]  be;
        int          a, b, c;
        logic [31:0] ea, eb, ec, eb1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int busy_cnt;
        int done_cnt;

        tbl[0] = '{1, 7, 32'hAABBCCDD, 4'hF, 7, 5, 0,
                   32'hAABBCCDD, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{1, 7, 32'h11223344, 4'b0101, 7, 3, 0,
                   32'hAA22CC44, 32'h0, 32'h0, 32'h0};
        tbl[2] = '{0, 0, 32'h0, 4'h0, 7, 0, 31,
                   32'hAA22CC44, 32'h0, 32'h0, 32'h0};
        tbl[3] = '{1, 0, 32'hFFFFFFFF, 4'hF, 0, 7, 0,
                   32'h0, 32'hAA22CC44, 32'h0, 32'hAA22CC44};
        tbl[4] = '{0, 0, 32'h0, 4'h0, 0, 31, 7,
                   32'h0, 32'h0, 32'hAA22CC44, 32'h0};
        tbl[5] = '{1, 3, 32'h12345678, 4'hF, 7, 3, 0,
                   32'hAA22CC44, 32'h12345678, 32'h0, 32'h0};
        tbl[6] = '{0, 0, 32'h0, 4'h0, 3, 3, 7,
                   32'h12345678, 32'h12345678, 32'hAA22CC44, 32'h12345678};
        tbl[7] = '{1, 5, 32'h0000AB00, 4'b0010, 5, 5, 3,
                   32'h0000AB00, 32'h0000AB00, 32'h12345678, 32'h0};

        rf.RegWrite = 0; rf.regW = 0; rf.Wdat = 0; rf.Wbe = 0;
        rf.regA = 5; rf.regB = 31; rf.regC = 0; rf.clr_req = 0;

        #2 rst_n = 0;
        #1;
        chk("rst_Adat", rf.Adat, 32'h0);
        chk("rst_Bdat", rf.Bdat, 32'h0);
        chk("rst_Cdat", rf.Cdat, 32'h0);
        chk("rst_busy", {31'b0, rf.busy}, 32'h0);
        chk("rst_done", {31'b0, rf.clr_done}, 32'h0);
        m_reset();
        @(posedge btn); #1 rst_n = 1;
        @(negedge btn); #1;

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be,
                  tbl[i].a, tbl[i].b, tbl[i].c, 0);
            chk($sformatf("tbl%0d_A", i), s_a, tbl[i].ea);
            chk($sformatf("tbl%0d_B", i), s_b, tbl[i].eb);
            chk($sformatf("tbl%0d_C", i), s_c, tbl[i].ec);
            chk($sformatf("tbl%0d_B_nobypass", i), s1_b, tbl[i].eb1);
        end

        // Soft clear with a write held on r9 throughout the sweep.
        for (int i = 1; i < 32; i++)
            cycle(1, i, i * 32'h01010101, 4'hF, i, 0, 31, 0);
        cycle(0, 0, 0, 0, 9, 1, 31, 1);
        chk("clr_start_busy", {31'b0, s_busy}, 32'h0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cycle(1, 9, 32'hDEAD, 4'hF, k, 9, 31, 0);
            busy_cnt += int'(s_busy);
            done_cnt += int'(s_done);
        end
        cycle(0, 0, 0, 0, 9, 31, 1, 0);
        busy_cnt += int'(s_busy);
        done_cnt += int'(s_done);
        chk("clr_done_pulse", {31'b0, s_done}, 32'h1);
        cycle(0, 0, 0, 0, 9, 31, 1, 0);
        done_cnt += int'(s_done);
        chk("busy_edges", 32'(busy_cnt), 32'd32);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("r9_dropped", s_a, 32'h0);
        for (int i = 0; i < 32; i++) begin
            cycle(0, 0, 0, 0, i, i, i, 0);
            chk("clr_zero", s_a, 32'h0);
        end

        // Reset in the middle of a sweep.
        cycle(1, 1, 32'h77, 4'hF, 1, 2, 0, 0);
        cycle(1, 2, 32'h88, 4'hF, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, 1, 2, 31, 1);
        for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0, 1, 2, 31, 0);
        #2 rst_n = 0;
        #1;
        chk("midclr_busy", {31'b0, rf.busy}, 32'h0);
        chk("midclr_r1", rf.Adat, 32'h0);
        chk("midclr_r2", rf.Bdat, 32'h0);
        m_reset();
        @(posedge btn); #1 rst_n = 1;
        @(negedge btn); #1;
        cycle(1, 1, 32'h77, 4'hF, 1, 2, 0, 0);
        cycle(1, 2, 32'h88, 4'hF, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, 1, 2, 31, 1);
        cycle(0, 0, 0, 0, 1, 2, 31, 0);
        cycle(0, 0, 0, 0, 1, 2, 31, 0);
        chk("restart_r1_held", s_a, 32'h77);
        cycle(0, 0, 0, 0, 1, 2, 31, 0);
        chk("restart_r1_zero", s_a, 32'h0);
        chk("restart_r2_held", s_b, 32'h88);
        for (int k = 0; k < 32; k++) cycle(0, 0, 0, 0, 1, 2, 31, 0);

        // Write and clear request on the same edge.
        cycle(1, 4, 32'h55, 4'hF, 4, 4, 4, 1);
        chk("simul_bypass", s_a, 32'h55);
        for (int k = 1; k <= 33; k++) begin
            cycle(0, 0, 0, 0, 4, 0, 31, 0);
            chk($sformatf("simul_r4_k%0d", k), s_a, (k <= 5) ? 32'h55 : 32'h0);
        end
        cycle(0, 0, 0, 0, 4, 0, 31, 0);

        for (int n = 0; n < 400; n++) begin
            cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                  32'($urandom), 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), $urandom_range(0, 49) == 0);
        end
        for (int n = 0; n < 40; n++)
            cycle(0, 0, 0, 0, n % 32, (n + 7) % 32, (n + 13) % 32, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
